w5300_bus_arbiter: RTL

Shares the W5300 8-bit host bus between two word-level requesters: the interrupt service engine (port 0) and the UART command path (port 1). Each 16-bit register access is sequenced as two timed 8-bit cycles, MSB at the even address first, with programmable setup, strobe and hold lengths. The block also synchronizes `int_n` for the service engine. It sits between the command/service logic and the top-level `data_bus` tristate.

---
 rtl/w5300_bus_pkg.sv | 27 ++
 rtl/w5300_bus_arbiter_if.sv | 46 ++++
 rtl/w5300_byte_cycle.sv | 101 ++++++++++
 rtl/w5300_bus_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/w5300_bus_pkg.sv
// Shared state encoding, timing defaults and register addresses for the
// W5300 host-bus arbiter and its byte timer.
package w5300_bus_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam bit BYTE_MSB_FIRST = 1'b1;

    localparam int T_SETUP_DEF    = 1;
    localparam int T_STROBE_DEF   = 2;
    localparam int T_HOLD_DEF     = 1;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic [9:0] IR        = 10'h002;
    localparam logic [9:0] S0_IR     = 10'h206;
    localparam logic [9:0] S0_TX_FSR = 10'h224;

    // Byte index 0 lands on the even address, which carries the MSB.
    function automatic logic is_msb(input logic b);
        return b ^ BYTE_MSB_FIRST;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic b);
        return is_msb(b) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/w5300_bus_arbiter_if.sv
// Request ports of both requesters plus the W5300 8-bit host-bus pins.
interface w5300_bus_arbiter_if;

    logic        req0_valid;
    logic        req0_we;
    logic [9:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        req0_ready;
    logic        req0_done;

    logic        req1_valid;
    logic        req1_we;
    logic [9:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        req1_ready;
    logic        req1_done;

    logic [15:0] rdata;

    logic [9:0]  addr;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [7:0]  data_o;
    logic        data_oe;
    logic [7:0]  data_i;
    logic        int_n;
    logic        irq;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  data_i, int_n,
        output req0_ready, req0_done, req1_ready, req1_done, rdata,
        output addr, cs, rd, wr, data_o, data_oe, irq
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output data_i, int_n,
        input  req0_ready, req0_done, req1_ready, req1_done, rdata,
        input  addr, cs, rd, wr, data_o, data_oe, irq
    );

endinterface

// File: rtl/w5300_byte_cycle.sv
// Times one 8-bit W5300 access (SETUP/STROBE/HOLD). A start seen on the last
// HOLD clock chains straight into the next byte so cs stays low.
module w5300_byte_cycle
    import w5300_bus_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic we,
    output logic cs,
    output logic rd,
    output logic wr,
    output logic sample,
    output logic finish
);

    localparam int T_SS  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int T_MAX = (T_SS > T_HOLD) ? T_SS : T_HOLD;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP);
    localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD);

    state_t        phase;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic          last;

    assign last   = (cnt == CW'(1));
    assign sample = (phase == STROBE) && last;
    assign finish = (phase == HOLD) && last;

    // Strobes are registered and change together with the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
            cs    <= 1'b1;
            rd    <= 1'b1;
            wr    <= 1'b1;
        end else begin
            case (phase)
                IDLE: begin
                    if (start) begin
                        phase <= SETUP;
                        cnt   <= LD_SETUP;
                        we_q  <= we;
                        cs    <= 1'b0;
                    end
                end
                SETUP: begin
                    if (last) begin
                        phase <= STROBE;
                        cnt   <= LD_STROBE;
                        rd    <= we_q;
                        wr    <= !we_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                STROBE: begin
                    if (last) begin
                        phase <= HOLD;
                        cnt   <= LD_HOLD;
                        rd    <= 1'b1;
                        wr    <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (last) begin
                        if (start) begin
                            phase <= SETUP;
                            cnt   <= LD_SETUP;
                            we_q  <= we;
                        end else begin
                            phase <= IDLE;
                            cs    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    phase <= IDLE;
                    cs    <= 1'b1;
                    rd    <= 1'b1;
                    wr    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Shares the W5300 8-bit host bus between the interrupt engine (port 0) and
// the UART command path (port 1); each word access is two byte cycles.
module w5300_bus_arbiter
    import w5300_bus_pkg::*;
#(
    parameter int T_SETUP    = T_SETUP_DEF,
    parameter int T_STROBE   = T_STROBE_DEF,
    parameter int T_HOLD     = T_HOLD_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    w5300_bus_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t        state;
    logic          b;
    logic          owner;
    logic          we_q;
    logic [8:0]    word_q;
    logic [15:0]   wdata_q;
    logic [SW-1:0] starve;
    logic [15:0]   rdata_q;
    logic [9:0]    addr_q;
    logic [7:0]    data_o_q;
    logic          data_oe_q;
    logic          done0_q;
    logic          done1_q;
    logic [1:0]    irq_sync;

    logic          grant1;
    logic          accept;
    logic          start;
    logic          cyc_we;
    logic          cyc_sample;
    logic          cyc_finish;
    logic          sel_we;
    logic [8:0]    sel_word;
    logic [15:0]   sel_wdata;

    // Port 0 wins unless port 1 has already watched STARVE_MAX port-0 grants.
    assign grant1    = bus.req1_valid && (!bus.req0_valid || starve == SW'(STARVE_MAX));
    assign accept    = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign sel_we    = grant1 ? bus.req1_we : bus.req0_we;
    assign sel_word  = grant1 ? bus.req1_addr[9:1] : bus.req0_addr[9:1];
    assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;

    assign start  = accept || ((state == SETUP) && cyc_finish && !b);
    assign cyc_we = accept ? sel_we : we_q;

    assign bus.req0_ready = accept && !grant1;
    assign bus.req1_ready = accept && grant1;
    assign bus.req0_done  = done0_q;
    assign bus.req1_done  = done1_q;
    assign bus.rdata      = rdata_q;
    assign bus.addr       = addr_q;
    assign bus.data_o     = data_o_q;
    assign bus.data_oe    = data_oe_q;
    assign bus.irq        = irq_sync[1];

    w5300_byte_cycle #(
        .T_SETUP  (T_SETUP),
        .T_STROBE (T_STROBE),
        .T_HOLD   (T_HOLD)
    ) u_byte_cycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .we     (cyc_we),
        .cs     (bus.cs),
        .rd     (bus.rd),
        .wr     (bus.wr),
        .sample (cyc_sample),
        .finish (cyc_finish)
    );

    // SETUP here spans the whole two-byte window; the byte timer owns the
    // fine SETUP/STROBE/HOLD phasing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            b         <= 1'b0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            starve    <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            data_o_q  <= '0;
            data_oe_q <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            if (!bus.req1_valid) begin
                starve <= '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= grant1;
                        we_q      <= sel_we;
                        word_q    <= sel_word;
                        wdata_q   <= sel_wdata;
                        b         <= 1'b0;
                        addr_q    <= {sel_word, 1'b0};
                        data_o_q  <= pick_byte(sel_wdata, 1'b0);
                        data_oe_q <= sel_we;
                        state     <= SETUP;
                        if (grant1) begin
                            starve <= '0;
                        end else if (bus.req1_valid) begin
                            starve <= starve + SW'(1);
                        end
                    end
                end
                SETUP: begin
                    if (cyc_sample && !we_q) begin
                        if (is_msb(b)) begin
                            rdata_q[15:8] <= bus.data_i;
                        end else begin
                            rdata_q[7:0] <= bus.data_i;
                        end
                    end
                    if (cyc_finish) begin
                        if (!b) begin
                            b        <= 1'b1;
                            addr_q   <= {word_q, 1'b1};
                            data_o_q <= pick_byte(wdata_q, 1'b1);
                        end else begin
                            data_oe_q <= 1'b0;
                            state     <= DONE;
                            done0_q   <= !owner;
                            done1_q   <= owner;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // int_n is asynchronous to clk, so it goes through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync <= 2'b00;
        end else begin
            irq_sync <= {irq_sync[0], !bus.int_n};
        end
    end

endmodule
